// File: rtl/wam_pkg.sv
// Shared types and helpers for the whack-a-mole game controller.
package wam_pkg;

    localparam int MAX_MOLES = 16;
    localparam int CNT_W     = $clog2(MAX_MOLES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        HIGHSCORE = 2'd2
    } game_state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_MOLES-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_MOLES; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/wam_game_ctrl_edge.sv
// Rising-edge detector: the registered history is compared against the live
// level, so a rise is visible in the same cycle the input goes high.
module wam_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/wam_game_ctrl.sv
// Whack-a-mole game controller: IDLE/PLAY/HIGHSCORE sequencing, countdown,
// saturating score and persistent high score. Optional macro: WAM_MISS_PENALTY_EN.
module wam_game_ctrl
    import wam_pkg::*;
#(
    parameter  int NUM_MOLES    = 4,
    parameter  int SCORE_W      = 8,
    parameter  int GAME_SECONDS = 30,
    localparam int TIME_W       = $clog2(GAME_SECONDS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start_btn,
    input  logic [NUM_MOLES-1:0] mole_mask,
    input  logic [NUM_MOLES-1:0] whack,
    output logic [1:0]           state,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   high_score,
    output logic [TIME_W-1:0]    time_left,
    output logic [NUM_MOLES-1:0] mole_clear,
    output logic                 game_over,
    output logic                 new_high
);

    // Wide enough to hold score + all hits, or score - all misses, as signed.
    localparam int SUM_W = SCORE_W + $clog2(NUM_MOLES) + 2;
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'((64'd1 << SCORE_W) - 64'd1);

    game_state_t            r_state;
    logic [SCORE_W-1:0]     r_score;
    logic [SCORE_W-1:0]     r_high_score;
    logic [TIME_W-1:0]      r_time_left;
    logic [NUM_MOLES-1:0]   r_mole_clear;
    logic                   r_game_over;
    logic                   r_new_high;

    logic                   w_start_rise;
    logic [NUM_MOLES-1:0]   w_whack_rise;
    logic [NUM_MOLES-1:0]   w_hit;
    logic [SUM_W-1:0]       w_hit_cnt;
    logic [SUM_W-1:0]       w_sum;
    logic [SCORE_W-1:0]     w_score_next;
    logic                   w_timeout;
    logic                   w_game_end;

    wam_edge_detect #(.WIDTH(1)) u_start_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (start_btn),
        .o_rise  (w_start_rise)
    );

    wam_edge_detect #(.WIDTH(NUM_MOLES)) u_whack_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (whack),
        .o_rise  (w_whack_rise)
    );

    assign w_hit     = w_whack_rise & mole_mask;
    assign w_hit_cnt = SUM_W'(popcount(MAX_MOLES'(w_hit)));

`ifdef WAM_MISS_PENALTY_EN
    logic [NUM_MOLES-1:0] w_miss;
    logic [SUM_W-1:0]     w_miss_cnt;

    assign w_miss     = w_whack_rise & ~mole_mask;
    assign w_miss_cnt = SUM_W'(popcount(MAX_MOLES'(w_miss)));
    assign w_sum      = SUM_W'(r_score) + w_hit_cnt - w_miss_cnt;
`else
    assign w_sum      = SUM_W'(r_score) + w_hit_cnt;
`endif

    // Clamp in the signed domain: the MSB flags a negative result.
    always_comb begin
        w_score_next = w_sum[SCORE_W-1:0];
        if (w_sum[SUM_W-1]) begin
            w_score_next = '0;
        end else if ($signed(w_sum) > $signed(SCORE_MAX)) begin
            w_score_next = '1;
        end
    end

    assign w_timeout  = tick && (r_time_left == TIME_W'(1));
    assign w_game_end = w_timeout || w_start_rise;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_score      <= '0;
            r_high_score <= '0;
            r_time_left  <= '0;
            r_mole_clear <= '0;
            r_game_over  <= 1'b0;
            r_new_high   <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here; a later assignment in the same cycle overrides.
            r_mole_clear <= '0;
            r_game_over  <= 1'b0;
            case (r_state)
                IDLE, HIGHSCORE: begin
                    if (w_start_rise) begin
                        r_state     <= PLAY;
                        r_score     <= '0;
                        r_time_left <= TIME_W'(GAME_SECONDS);
                        r_new_high  <= 1'b0;
                    end
                end
                PLAY: begin
                    r_mole_clear <= w_hit;
                    r_score      <= w_score_next;
                    if (w_game_end) begin
                        r_state     <= HIGHSCORE;
                        r_game_over <= 1'b1;
                        if (w_timeout) begin
                            r_time_left <= '0;
                        end
                        if (w_score_next > r_high_score) begin
                            r_high_score <= w_score_next;
                            r_new_high   <= 1'b1;
                        end
                    end else if (tick) begin
                        r_time_left <= r_time_left - TIME_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign state      = r_state;
    assign score      = r_score;
    assign high_score = r_high_score;
    assign time_left  = r_time_left;
    assign mole_clear = r_mole_clear;
    assign game_over  = r_game_over;
    assign new_high   = r_new_high;

endmodule

// File: tb/tb_wam_game_ctrl.sv
// Directed bench for wam_game_ctrl (NUM_MOLES=4, SCORE_W=4, GAME_SECONDS=30).
module tb_wam_game_ctrl;

`ifdef WAM_MISS_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       start_btn;
    logic [3:0] mole_mask;
    logic [3:0] whack;
    logic [1:0] state;
    logic [3:0] score;
    logic [3:0] high_score;
    logic [4:0] time_left;
    logic [3:0] mole_clear;
    logic       game_over;
    logic       new_high;

    int n_checks = 0;
    int n_fail   = 0;

    wam_game_ctrl #(
        .NUM_MOLES    (4),
        .SCORE_W      (4),
        .GAME_SECONDS (30)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start_btn  (start_btn),
        .mole_mask  (mole_mask),
        .whack      (whack),
        .state      (state),
        .score      (score),
        .high_score (high_score),
        .time_left  (time_left),
        .mole_clear (mole_clear),
        .game_over  (game_over),
        .new_high   (new_high)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       tk;
        logic [3:0] m;
        logic [3:0] w;
        logic [1:0] e_state;
        logic [3:0] e_score;
        logic [4:0] e_tl;
        logic [3:0] e_mc;
        logic       e_go;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(input logic st, input logic tk, input logic [3:0] m,
                                input logic [3:0] w, input logic [1:0] es, input int esc,
                                input int etl, input logic [3:0] emc, input logic ego);
        vec_t v;
        v.st = st; v.tk = tk; v.m = m; v.w = w;
        v.e_state = es; v.e_score = 4'(esc); v.e_tl = 5'(etl); v.e_mc = emc; v.e_go = ego;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input int st, input int sc, input int hs,
                           input int tl, input int mc, input int go, input int nh);
        check({name, ".state"},      32'(state),      32'(st));
        check({name, ".score"},      32'(score),      32'(sc));
        check({name, ".high_score"}, 32'(high_score), 32'(hs));
        check({name, ".time_left"},  32'(time_left),  32'(tl));
        check({name, ".mole_clear"}, 32'(mole_clear), 32'(mc));
        check({name, ".game_over"},  32'(game_over),  32'(go));
        check({name, ".new_high"},   32'(new_high),   32'(nh));
    endtask

    // One whack press with the given mole mask, then release.
    task automatic whack_pulse(input string name, input logic [3:0] m, input logic [3:0] w,
                               input int e_score, input logic [3:0] e_mc);
        mole_mask = m;
        whack     = w;
        step();
        check({name, ".score"},      32'(score),      32'(e_score));
        check({name, ".mole_clear"}, 32'(mole_clear), 32'(e_mc));
        whack = 4'b0000;
        step();
        check({name, ".clear_drop"}, 32'(mole_clear), 32'd0);
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; start_btn = 1'b0; mole_mask = '0; whack = '0;

        vecs[0] = mk(0, 1, 4'b0000, 4'b0000, 2'd0, 0,       0,  4'b0000, 0);
        vecs[1] = mk(1, 0, 4'b0000, 4'b0000, 2'd1, 0,       30, 4'b0000, 0);
        vecs[2] = mk(1, 0, 4'b0101, 4'b0101, 2'd1, 2,       30, 4'b0101, 0);
        vecs[3] = mk(1, 0, 4'b0101, 4'b0101, 2'd1, 2,       30, 4'b0000, 0);
        vecs[4] = mk(1, 0, 4'b0101, 4'b0000, 2'd1, 2,       30, 4'b0000, 0);
        vecs[5] = mk(1, 0, 4'b0010, 4'b1000, 2'd1, 2 - PEN, 30, 4'b0000, 0);
        vecs[6] = mk(1, 1, 4'b0010, 4'b1000, 2'd1, 2 - PEN, 29, 4'b0000, 0);
        vecs[7] = mk(0, 0, 4'b1111, 4'b1111, 2'd1, 5 - PEN, 29, 4'b0111, 0);
        vecs[8] = mk(0, 0, 4'b1111, 4'b0000, 2'd1, 5 - PEN, 29, 4'b0000, 0);

        repeat (2) step();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            start_btn = vecs[i].st;
            tick      = vecs[i].tk;
            mole_mask = vecs[i].m;
            whack     = vecs[i].w;
            step();
            check($sformatf("vec%0d.state", i),      32'(state),      32'(vecs[i].e_state));
            check($sformatf("vec%0d.score", i),      32'(score),      32'(vecs[i].e_score));
            check($sformatf("vec%0d.time_left", i),  32'(time_left),  32'(vecs[i].e_tl));
            check($sformatf("vec%0d.mole_clear", i), 32'(mole_clear), 32'(vecs[i].e_mc));
            check($sformatf("vec%0d.game_over", i),  32'(game_over),  32'(vecs[i].e_go));
        end

        // Countdown to 1, then time out with a hit in the final tick cycle.
        tick = 1'b1;
        repeat (28) step();
        check("countdown.time_left", 32'(time_left), 32'd1);
        check("countdown.state",     32'(state),     32'd1);
        mole_mask = 4'b0001;
        whack     = 4'b0001;
        step();
        chk_all("timeout", 2, 6 - PEN, 6 - PEN, 0, 4'b0001, 1, 1);
        whack = 4'b0000;
        step();
        chk_all("hs_hold", 2, 6 - PEN, 6 - PEN, 0, 0, 0, 1);
        tick      = 1'b0;
        mole_mask = 4'b1111;
        whack     = 4'b1111;
        step();
        chk_all("hs_whack", 2, 6 - PEN, 6 - PEN, 0, 0, 0, 1);
        whack = 4'b0000;
        step();

        // Game 2: start held through play, equal final score, abort keeps time.
        start_btn = 1'b1;
        step();
        chk_all("g2_start", 1, 0, 6 - PEN, 30, 0, 0, 0);
        tick = 1'b1;
        repeat (2) step();
        tick = 1'b0;
        check("g2_held.state",     32'(state),     32'd1);
        check("g2_held.time_left", 32'(time_left), 32'd28);
        whack_pulse("g2_hit4", 4'b1111, 4'b1111, 4, 4'b1111);
        whack_pulse("g2_hit2", (PEN != 0) ? 4'b0001 : 4'b0011,
                    (PEN != 0) ? 4'b0001 : 4'b0011, 6 - PEN,
                    (PEN != 0) ? 4'b0001 : 4'b0011);
        check("g2_still_play", 32'(state), 32'd1);
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        chk_all("g2_abort", 2, 6 - PEN, 6 - PEN, 28, 0, 1, 0);

        // Game 3: saturation at 15 with SCORE_W=4.
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        check("g3_start.score", 32'(score), 32'd0);
        whack_pulse("g3_a", 4'b1111, 4'b1111, 4,  4'b1111);
        whack_pulse("g3_b", 4'b1111, 4'b1111, 8,  4'b1111);
        whack_pulse("g3_c", 4'b1111, 4'b1111, 12, 4'b1111);
        whack_pulse("g3_d", 4'b0011, 4'b0011, 14, 4'b0011);
        whack_pulse("g3_sat", 4'b1111, 4'b0111, 15, 4'b0111);
        whack_pulse("g3_nowrap", 4'b1111, 4'b1111, 15, 4'b1111);
        check("g3_state", 32'(state), 32'd1);

        // Reset mid-game clears everything including high score.
        rst       = 1'b0;
        start_btn = 1'b0;
        tick      = 1'b0;
        mole_mask = '0;
        whack     = '0;
        step();
        chk_all("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        check("post_reset.state", 32'(state), 32'd0);

        // Game 4: misses (penalised only with WAM_MISS_PENALTY_EN).
        start_btn = 1'b1;
        step();
        chk_all("g4_start", 1, 0, 0, 30, 0, 0, 0);
        whack_pulse("g4_hit",   4'b0001, 4'b0001, 1,       4'b0001);
        whack_pulse("g4_miss2", 4'b0000, 4'b0110, 1 - PEN, 4'b0000);
        whack_pulse("g4_clamp", 4'b0000, 4'b1000, 1 - PEN, 4'b0000);
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        chk_all("g4_end", 2, 1 - PEN, 1 - PEN, 30, 0, 1, 1 - PEN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
